muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer beside the main ALU. The control FSM issues a one-cycle start with operands from regA/regB and stalls while busy. The block runs a 32-iteration shift-add multiply or restoring divide, then writes HI/LO for later MFHI/MFLO through mux_mem2reg.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE or DONE
op  in  2  00 MULT, 01 DIV, 10 MULTU, 11 DIVU; op[1] is used only with MULDIV_UNSIGNED_EN
a  in  WIDTH  operand A (rs): multiplicand or dividend
b  in  WIDTH  operand B (rt): multiplier or divisor
busy  out  1  high in PREP, RUN and FIX; control FSM holds its state while high
done  out  1  one-cycle pulse; hi/lo valid in the same cycle
div_zero  out  1  one-cycle pulse with done when a divide has b==0
hi  out  WIDTH  HI register: product[63:32] or remainder
lo  out  WIDTH  LO register: product[31:0] or quotient

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; hi, lo, done, div_zero, the counter and internal registers all 0; busy=0. Reset mid-operation aborts the operation; no partial result is kept.
- States: IDLE, PREP, RUN, FIX, DONE.
  - IDLE/DONE + start -> PREP. DONE without start -> IDLE. done and div_zero are high only in DONE.
- PREP (1 cycle):
  - latch sign_a=a[W-1] and sign_b=b[W-1] (signed ops only).
  - latch magnitudes |a| and |b| as unsigned WIDTH bits; |0x80000000| = 0x80000000.
  - counter=WIDTH-1.
  - Signed or unsigned divide with b==0 -> DONE, div_zero=1, hi/lo unchanged. Otherwise -> RUN.
- RUN (exactly WIDTH cycles, counter WIDTH-1 down to 0):
  - Multiply: 2W-bit accumulator {P,multiplier}. If the LSB is 1, add the multiplicand into the upper half with carry. Then shift right 1.
  - Divide: 2W-bit remainder:quotient. Shift left 1, trial-subtract the divisor from the upper half. If the result is non-negative, keep it and set quotient LSB=1.
  - counter==0 -> FIX.
- FIX (1 cycle):
  - Multiply: if sign_a^sign_b, negate the 2W-bit product (two's complement).
  - Divide: if sign_a^sign_b, negate the quotient; if sign_a, negate the remainder.
  - Register hi/lo at the end of FIX; assert done. -> DONE.
- Latency: start in cycle 0 gives busy in cycles 1..34 and done in cycle 35. A divide by zero gives done in cycle 2.
- start while busy is ignored; no queueing.
- hi/lo hold their value except on a completed non-zero operation.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no flag).
- Inputs a, b and op are sampled only in PREP and may change afterwards.

Optional Feature:
MULDIV_UNSIGNED_EN
- Defined: op[1]=1 selects MULTU/DIVU. Sign latches are forced 0, operands are used raw and FIX does no negation.
- Undefined: op[1] is ignored, every op is signed, and MULTU/DIVU are decoded upstream as illegal.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT, OP_DIV, OP_MULTU, OP_DIVU
  - the 3-bit state encoding
  - localparam ITER=WIDTH
- One sub-module, muldiv_step: combinational single-iteration add/shift and subtract/shift on the 2W-bit working register, selected by is_div. It is instantiated once inside the FSM.

Test Plan:
- MULT a=7, b=0xFFFFFFFD -> done at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high cycles 1..34.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=5, b=0 with hi/lo preloaded 0x1111/0x2222 -> done and div_zero in cycle 2, hi/lo unchanged, busy cycle 1 only.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Second start pulsed in cycle 10 of a MULT -> ignored, single done. rst low in cycle 20 -> hi=lo=0, busy=0 immediately. Fresh start after release completes normally.
- With MULDIV_UNSIGNED_EN: MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE; DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide sequencer.
//   - op encodings (op[0] selects divide, op[1] selects unsigned)
//   - FSM state encoding (3 bits)
//   - ITER: iteration count, equal to the default operand width
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the 2W-bit working register.
//   acc    : working register ({P, multiplier} or {remainder, quotient})
//   opnd   : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   is_div : 0 = shift-add multiply step, 1 = restoring divide step
//   nxt    : working register after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] nxt
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] div_nxt;

    // Multiply: conditional add into the upper half, the carry becomes the
    // new MSB after the right shift.
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {sum, acc[WIDTH-1:1]};

    // Divide: the shifted remainder needs WIDTH+1 bits, since a remainder
    // just below a large divisor doubles past 2^WIDTH. When ge holds the
    // difference is below 2^WIDTH, so a WIDTH-bit modular subtract is exact.
    assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign ge      = rem_sh >= {1'b0, opnd};
    assign diff    = rem_sh[WIDTH-1:0] - opnd;
    assign div_nxt = {(ge ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};

    assign nxt = is_div ? div_nxt : mul_nxt;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle signed/unsigned multiply and restoring divide.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : one-cycle request, honoured in IDLE or DONE only
//   op       : 00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//   a, b     : operands, sampled in PREP only
//   busy     : high in PREP, RUN, FIX
//   done     : one-cycle pulse in DONE, hi/lo valid
//   div_zero : pulses with done for a divide by zero (hi/lo untouched)
//   hi, lo   : product[2W-1:W]/product[W-1:0] or remainder/quotient
// Optional feature macro: MULDIV_UNSIGNED_EN (enables op[1] unsigned ops;
// without it every op is treated as signed).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               uns;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] step_nxt;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo, rem;

`ifdef MULDIV_UNSIGNED_EN
    assign uns = op[1];
`else
    logic unused_op1;
    assign uns        = 1'b0;
    assign unused_op1 = op[1];
`endif

    // Magnitudes as unsigned; -(0x80..0) wraps back to 0x80..0, which is
    // already the correct unsigned magnitude.
    assign a_neg = ~uns & a[WIDTH-1];
    assign b_neg = ~uns & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc    (acc_q),
        .opnd   (opnd_q),
        .is_div (is_div_q),
        .nxt    (step_nxt)
    );

    assign prod_neg = ~acc_q + 1'b1;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_PREP;
            end
            S_PREP: begin
                sign_a_d = a_neg;
                sign_b_d = b_neg;
                is_div_d = op[0];
                cnt_d    = CW'(WIDTH - 1);
                // Multiply: {0, multiplier}, multiplicand held aside.
                // Divide:   {0, dividend},   divisor held aside.
                acc_d    = {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
                opnd_d   = op[0] ? b_mag : a_mag;
                if (op[0] && (b == '0)) begin
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = step_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = (sign_a_q ^ sign_b_q) ? (~quo + 1'b1) : quo;
                    hi_d = sign_a_q ? (~rem + 1'b1) : rem;
                end else begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : acc_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                dz_d    = 1'b0;
                state_d = start ? S_PREP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = done & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
